// File: rtl/color_blob_centroid_pkg.sv
// Shared types and default geometry for the colour-blob centroid tracker.
// Default widths are derived from the active window so the accumulators cannot overflow.
package color_blob_centroid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_X,
        ST_DIV_Y,
        ST_PUBLISH
    } state_t;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int XW_DEF         = $clog2(H_ACTIVE_DEF);
    localparam int YW_DEF         = $clog2(V_ACTIVE_DEF);
    localparam int CW_DEF         = $clog2(H_ACTIVE_DEF * V_ACTIVE_DEF + 1);
    localparam int SW_DEF         = $clog2(H_ACTIVE_DEF * V_ACTIVE_DEF * (H_ACTIVE_DEF - 1) + 1);
    localparam int MIN_PIXELS_DEF = 64;

    typedef struct packed {
        logic [7:0] r_min;
        logic [7:0] r_max;
        logic [7:0] g_min;
        logic [7:0] g_max;
        logic [7:0] b_min;
        logic [7:0] b_max;
    } box_t;

    // Power-up box accepts every colour.
    localparam box_t BOX_ALL = '{
        r_min: 8'd0, r_max: 8'd255,
        g_min: 8'd0, g_max: 8'd255,
        b_min: 8'd0, b_max: 8'd255
    };

    // Inclusive unsigned test; an inverted range naturally rejects everything.
    function automatic logic in_box(box_t bx, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        return (r >= bx.r_min) && (r <= bx.r_max) &&
               (g >= bx.g_min) && (g <= bx.g_max) &&
               (b >= bx.b_min) && (b <= bx.b_max);
    endfunction

endpackage

// File: rtl/color_blob_centroid_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// done pulses SW+1 cycles after start; abort drops an in-flight division silently.
module seq_divider #(
    parameter int SW = 28,
    parameter int CW = 19
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic [SW-1:0] quotient,
    output logic          done
);

    localparam int NW = $clog2(SW + 1);

    logic [NW-1:0] cnt;
    logic          busy;
    logic [CW-1:0] rem;
    logic [CW-1:0] dvs;
    logic [SW-1:0] quo;
    logic [CW:0]   rem_sh;
    logic [CW:0]   diff;

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        rem_sh = {rem, quo[SW-1]};
        diff   = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= NW'(SW);
                rem  <= '0;
                dvs  <= divisor;
                quo  <= dividend;
            end else if (busy) begin
                rem <= diff[CW] ? rem_sh[CW-1:0] : diff[CW-1:0];
                quo <= {quo[SW-2:0], ~diff[CW]};
                cnt <= cnt - NW'(1);
                if (cnt == NW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/color_blob_centroid.sv
// Thresholds RGB pixel pairs against a per-frame colour box, accumulates match
// coordinates, and divides the sums at each vsync to publish the blob centroid.
module color_blob_centroid
    import color_blob_centroid_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int XW         = XW_DEF,
    parameter int YW         = YW_DEF,
    parameter int CW         = CW_DEF,
    parameter int SW         = SW_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          href,
    input  logic          vsync,
    input  logic          pair_valid,
    input  logic [7:0]    r1,
    input  logic [7:0]    g1,
    input  logic [7:0]    b1,
    input  logic [7:0]    r2,
    input  logic [7:0]    g2,
    input  logic [7:0]    b2,
    input  logic [7:0]    r_min,
    input  logic [7:0]    r_max,
    input  logic [7:0]    g_min,
    input  logic [7:0]    g_max,
    input  logic [7:0]    b_min,
    input  logic [7:0]    b_max,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic [CW-1:0] pix_count,
    output logic          found,
    output logic          result_valid,
    output logic          overrun
);

    localparam logic [XW:0]   H_LIM   = (XW + 1)'(H_ACTIVE);
    localparam logic [YW-1:0] V_LIM   = YW'(V_ACTIVE);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    logic          vs_q, vs_qq, href_q;
    logic          frame_end, href_fall;
    box_t          th;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW:0]   x0, x1;
    logic          m1, m2, acc_en;
    logic [1:0]    m_cnt;
    logic [SW-1:0] sx_inc, sy_inc;
    logic [CW-1:0] acc_count, lat_count;
    logic [SW-1:0] acc_sx, acc_sy, lat_sx, lat_sy;

    state_t        state, state_d;
    logic          started;
    logic          div_start, div_done;
    logic [SW-1:0] div_q;
    logic          qx_load, pub_load, pub_zero;
    logic [XW-1:0] qx;
    logic          unused_q;

    assign frame_end = vs_q & ~vs_qq;
    assign href_fall = href_q & ~href;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            vs_q   <= 1'b0;
            vs_qq  <= 1'b0;
            href_q <= 1'b0;
            th     <= BOX_ALL;
        end else begin
            vs_q   <= vsync;
            vs_qq  <= vs_q;
            href_q <= href;
            if (frame_end)
                th <= '{r_min: r_min, r_max: r_max, g_min: g_min,
                        g_max: g_max, b_min: b_min, b_max: b_max};
        end
    end

    // Raster position; y parks at V_ACTIVE so trailing lines are discarded.
    always_ff @(posedge pclk) begin
        if (!reset_n || vsync) begin
            x <= '0;
            y <= '0;
        end else if (href_fall) begin
            x <= '0;
            if (y < V_LIM)
                y <= y + YW'(1);
        end else if (pair_valid) begin
            x <= x + XW'(2);
        end
    end

    always_comb begin
        x0     = {1'b0, x};
        x1     = x0 + (XW + 1)'(1);
        acc_en = pair_valid & ~vsync & (y < V_LIM);
        m1     = in_box(th, r1, g1, b1) && (x0 < H_LIM);
        m2     = in_box(th, r2, g2, b2) && (x1 < H_LIM);
        m_cnt  = {1'b0, m1} + {1'b0, m2};
        sx_inc = (m1 ? SW'(x0) : '0) + (m2 ? SW'(x1) : '0);
        sy_inc = '0;
        if (m1) sy_inc = SW'(y);
        if (m2) sy_inc = sy_inc + SW'(y);
    end

    // vsync is already high when frame_end fires, so the handoff never races a pixel.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            acc_count <= '0;
            acc_sx    <= '0;
            acc_sy    <= '0;
            lat_count <= '0;
            lat_sx    <= '0;
            lat_sy    <= '0;
        end else if (frame_end) begin
            lat_count <= acc_count;
            lat_sx    <= acc_sx;
            lat_sy    <= acc_sy;
            acc_count <= '0;
            acc_sx    <= '0;
            acc_sy    <= '0;
        end else if (acc_en) begin
            acc_count <= acc_count + CW'(m_cnt);
            acc_sx    <= acc_sx + sx_inc;
            acc_sy    <= acc_sy + sy_inc;
        end
    end

    always_comb begin
        state_d   = state;
        div_start = 1'b0;
        qx_load   = 1'b0;
        pub_load  = 1'b0;
        pub_zero  = 1'b0;
        case (state)
            ST_IDLE: state_d = ST_IDLE;
            ST_DIV_X: begin
                if (lat_count == '0) begin
                    pub_zero = 1'b1;
                    state_d  = ST_PUBLISH;
                end else begin
                    div_start = ~started;
                    if (div_done) begin
                        qx_load = 1'b1;
                        state_d = ST_DIV_Y;
                    end
                end
            end
            ST_DIV_Y: begin
                div_start = ~started;
                if (div_done) begin
                    pub_load = 1'b1;
                    state_d  = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A new frame end always wins: any in-flight result is dropped.
        if (frame_end) begin
            state_d   = ST_DIV_X;
            div_start = 1'b0;
            qx_load   = 1'b0;
            pub_load  = 1'b0;
            pub_zero  = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            started <= 1'b0;
            qx      <= '0;
        end else begin
            state <= state_d;
            if (state_d != state || frame_end)
                started <= 1'b0;
            else if (div_start)
                started <= 1'b1;
            if (qx_load)
                qx <= div_q[XW-1:0];
        end
    end

    seq_divider #(
        .SW (SW),
        .CW (CW)
    ) u_div (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (frame_end),
        .dividend ((state == ST_DIV_Y) ? lat_sy : lat_sx),
        .divisor  (lat_count),
        .quotient (div_q),
        .done     (div_done)
    );

    // Result registers load on entry to PUBLISH so they line up with result_valid.
    always_ff @(posedge pclk) begin
        if (!reset_n || pub_zero) begin
            cx        <= '0;
            cy        <= '0;
            pix_count <= '0;
            found     <= 1'b0;
        end else if (pub_load) begin
            cx        <= qx;
            cy        <= div_q[YW-1:0];
            pix_count <= lat_count;
            found     <= (lat_count >= MIN_CNT);
        end
    end

    assign result_valid = (state == ST_PUBLISH);
    assign overrun      = frame_end && (state == ST_DIV_X || state == ST_DIV_Y);
    assign unused_q     = ^div_q[SW-1:XW];

endmodule

// File: tb/tb_color_blob_centroid.sv
// Randomized frame-level bench for color_blob_centroid with a pixel-list reference model.
module tb_color_blob_centroid;

    localparam int H = 107, V = 40, XW = 10, YW = 9, CW = 19, SW = 28, MINP = 64;

    logic          pclk = 1'b0;
    logic          reset_n, href, vsync, pair_valid;
    logic [7:0]    r1, g1, b1, r2, g2, b2;
    logic [7:0]    r_min, r_max, g_min, g_max, b_min, b_max;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [CW-1:0] pix_count;
    logic          found, result_valid, overrun;

    color_blob_centroid #(
        .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW), .SW(SW), .MIN_PIXELS(MINP)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .href(href), .vsync(vsync), .pair_valid(pair_valid),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max), .b_min(b_min), .b_max(b_max),
        .cx(cx), .cy(cy), .pix_count(pix_count), .found(found),
        .result_valid(result_valid), .overrun(overrun)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int            rv_cnt = 0, ov_cnt = 0, rv_cyc = 0;
    logic [XW-1:0] rv_cx;
    logic [YW-1:0] rv_cy;
    logic [CW-1:0] rv_pc;
    logic          rv_found;
    always @(negedge pclk) begin
        if (result_valid) begin
            rv_cnt   <= rv_cnt + 1;
            rv_cyc   <= cyc;
            rv_cx    <= cx;
            rv_cy    <= cy;
            rv_pc    <= pix_count;
            rv_found <= found;
        end
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: box in force for the current frame plus running sums.
    int     mb[6];
    longint e_cnt = 0, e_sx = 0, e_sy = 0;

    function automatic bit model_match(logic [23:0] c);
        return int'(c[23:16]) >= mb[0] && int'(c[23:16]) <= mb[1] &&
               int'(c[15:8])  >= mb[2] && int'(c[15:8])  <= mb[3] &&
               int'(c[7:0])   >= mb[4] && int'(c[7:0])   <= mb[5];
    endfunction

    task automatic model_px(input int px, input int py, input logic [23:0] c);
        if (px < H && py < V && model_match(c)) begin
            e_cnt++;
            e_sx += px;
            e_sy += py;
        end
    endtask

    function automatic logic [7:0] pick(input int lo, input int hi);
        if ($urandom_range(1, 0) == 1 && lo <= hi) return 8'($urandom_range(hi, lo));
        return 8'($urandom_range(255, 0));
    endfunction

    // mode 0: any colour; 1: one red target at (101,37), rest non-red; 2: biased into the box
    function automatic logic [23:0] gen_px(input int mode, input int px, input int py);
        if (mode == 1) begin
            if (px == 101 && py == 37) return 24'hFA0A0A;
            return {8'($urandom_range(199, 0)), 16'($urandom)};
        end
        if (mode == 2) return {pick(mb[0], mb[1]), pick(mb[2], mb[3]), pick(mb[4], mb[5])};
        return 24'($urandom);
    endfunction

    task automatic set_box(input int rl, input int rh, input int gl, input int gh,
                           input int bl, input int bh);
        r_min = 8'(rl); r_max = 8'(rh); g_min = 8'(gl);
        g_max = 8'(gh); b_min = 8'(bl); b_max = 8'(bh);
    endtask

    task automatic send_line(input int ln, input int np, input int mode);
        logic [23:0] p1, p2;
        @(negedge pclk);
        href = 1'b1;
        for (int p = 0; p < np; p++) begin
            p1 = gen_px(mode, 2 * p, ln);
            p2 = gen_px(mode, 2 * p + 1, ln);
            {r1, g1, b1} = p1;
            {r2, g2, b2} = p2;
            pair_valid = 1'b1;
            model_px(2 * p, ln, p1);
            model_px(2 * p + 1, ln, p2);
            @(negedge pclk);
            pair_valid = 1'b0;
            repeat ($urandom_range(1, 0)) @(negedge pclk);
        end
        href = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic latch_model_box();
        mb = '{int'(r_min), int'(r_max), int'(g_min), int'(g_max), int'(b_min), int'(b_max)};
    endtask

    // Closes the current frame with a vsync pulse and checks its published result.
    task automatic end_frame(input string nm);
        longint ec = e_cnt, esx = e_sx, esy = e_sy;
        int     rv0 = rv_cnt;
        int     vs_cyc;
        bit     got = 0;
        latch_model_box();
        e_cnt = 0; e_sx = 0; e_sy = 0;
        @(negedge pclk);
        vsync  = 1'b1;
        vs_cyc = cyc;
        repeat (3) @(negedge pclk);
        vsync = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge pclk);
            if (rv_cnt != rv0) got = 1;
        end
        chk({nm, "_seen"}, got, 1);
        if (got) begin
            chk({nm, "_pix_count"}, rv_pc, ec);
            chk({nm, "_cx"}, rv_cx, (ec == 0) ? 0 : esx / ec);
            chk({nm, "_cy"}, rv_cy, (ec == 0) ? 0 : esy / ec);
            chk({nm, "_found"}, rv_found, ec >= MINP);
            // vsync is driven one cycle before the edge that registers it
            if (ec == 0) chk({nm, "_lat_empty"}, (rv_cyc - vs_cyc) <= 4, 1);
            else         chk({nm, "_lat_bound"}, (rv_cyc - vs_cyc) <= 2 * (SW + 1) + 4, 1);
        end
        repeat (4) @(negedge pclk);
        chk({nm, "_once"}, rv_cnt - rv0, 1);
    endtask

    initial begin
        int nl, rv0, ov0;
        reset_n = 1'b0; href = 1'b0; vsync = 1'b0; pair_valid = 1'b0;
        {r1, g1, b1, r2, g2, b2} = '0;
        set_box(0, 255, 0, 255, 0, 255);
        latch_model_box();
        repeat (3) @(negedge pclk);
        reset_n = 1'b1;
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_pix_count", pix_count, 0);
        chk("rst_found", found, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_overrun", overrun, 0);

        end_frame("boot");
        for (int ln = 0; ln < 4; ln++) send_line(ln, 8, 0);
        set_box(200, 255, 0, 50, 0, 50);
        end_frame("full");
        for (int ln = 0; ln < 37; ln++) send_line(ln, 2, 1);
        send_line(37, 51, 1);
        set_box(10, 5, 0, 255, 0, 255);
        end_frame("red");
        for (int ln = 0; ln < 3; ln++) send_line(ln, 10, 0);
        set_box(0, 255, 0, 255, 0, 255);
        end_frame("empty");
        for (int ln = 0; ln < 3; ln++) send_line(ln, 55, 0);

        for (int f = 0; f < 4; f++) begin
            int lo[3], hi[3], a, b;
            for (int c = 0; c < 3; c++) begin
                a = $urandom_range(255, 0);
                b = $urandom_range(255, 0);
                lo[c] = (a < b) ? a : b;
                hi[c] = (a < b) ? b : a;
                if ($urandom_range(7, 0) == 0) begin
                    lo[c] = hi[c] + 1;
                    hi[c] = lo[c] - 1;
                end
            end
            set_box(lo[0], hi[0], lo[1], hi[1], lo[2], hi[2]);
            end_frame((f == 0) ? "hbound" : "rand");
            nl = (f == 0) ? V + 3 : $urandom_range(V + 3, 1);
            for (int ln = 0; ln < nl; ln++) send_line(ln, $urandom_range(56, 0), 2);
        end
        set_box(0, 255, 0, 255, 0, 255);
        end_frame("rand");

        // Overrun: second vsync lands early in the x division.
        for (int ln = 0; ln < 2; ln++) send_line(ln, 10, 0);
        rv0 = rv_cnt;
        ov0 = ov_cnt;
        latch_model_box();
        @(negedge pclk);
        vsync = 1'b1;
        repeat (2) @(negedge pclk);
        vsync = 1'b0;
        e_cnt = 0; e_sx = 0; e_sy = 0;
        send_line(0, 3, 0);
        end_frame("ovr");
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_results", rv_cnt - rv0, 1);

        // Reset while the y division is in flight.
        for (int ln = 0; ln < 2; ln++) send_line(ln, 8, 0);
        rv0 = rv_cnt;
        @(negedge pclk);
        vsync = 1'b1;
        repeat (3) @(negedge pclk);
        vsync = 1'b0;
        repeat (SW + 10) @(negedge pclk);
        reset_n = 1'b0;
        @(negedge pclk);
        reset_n = 1'b1;
        chk("mid_rst_cx", cx, 0);
        chk("mid_rst_cy", cy, 0);
        chk("mid_rst_pix_count", pix_count, 0);
        chk("mid_rst_found", found, 0);
        repeat (80) @(negedge pclk);
        chk("mid_rst_no_result", rv_cnt - rv0, 0);
        e_cnt = 0; e_sx = 0; e_sy = 0;
        mb = '{0, 255, 0, 255, 0, 255};
        for (int ln = 0; ln < 3; ln++) send_line(ln, 8, 0);
        end_frame("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
